reverse_lane_checker: RTL and testbench
=======================================

# reverse_lane_checker

Self-checking sweep stage for the three-lane bit-reverse datapath. It sits on both sides of the datapath. Upstream, it drives every 3-bit stimulus code into the shared lane input. Downstream, it samples the three returned lanes and compares each against the bit-reverse of the stimulus. It reports per-lane sticky error flags, a saturating mismatch count and the first failing code, so a miswired or width-truncated lane is caught in simulation and on the board.

## Interface
- `WIDTH`, 3: lane width in bits; stimulus sweeps 0 .. 2^WIDTH-1.
- `LANES`, 3: number of returned lanes checked.
- `SETTLE`, 2: cycles stimulus is held before sampling; must be ≥ 1.
- `PASSES`, 1: number of full sweeps per run; must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `stim`  out  WIDTH  stimulus to datapath input.
- `lane_in`  in  LANES*WIDTH  returned lanes; lane i = `lane_in[i*WIDTH +: WIDTH]`.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `err_flags`  out  LANES  sticky per-lane mismatch flag.
- `err_count`  out  8  total lane mismatches, saturating at 255.
- `first_err_valid`  out  1  a mismatch has been recorded this run.
- `first_err_code`  out  WIDTH  `stim` value at the first mismatch.

## Operation
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - On `start`=1, go to DRIVE.
  - Clear `err_flags`, `err_count`, `first_err_valid` and `first_err_code`.
  - Set `stim`=0, the settle counter to 0 and the pass counter to 0.
- DRIVE:
  - Hold `stim`; increment the settle counter.
  - After SETTLE cycles in DRIVE, go to CHECK.
- CHECK (one cycle):
  - Compare each lane with expected = bit-reverse(`stim`), i.e. expected[k] = stim[WIDTH-1-k].
  - Set `err_flags`[i] for every mismatching lane.
  - Add the number of mismatching lanes (0..LANES) to `err_count`, clamped at 255.
  - If `first_err_valid`=0 and any lane mismatches, set `first_err_valid`=1 and `first_err_code`=`stim`. Later mismatches do not overwrite these.
  - Advance `stim`, with wrap from 2^WIDTH-1 to 0.
  - If `stim` wrapped and the pass counter equals PASSES-1, go to DONE. Otherwise increment the pass counter on wrap and return to DRIVE with the settle counter reset.
- DONE (one cycle):
  - `done`=1, then go to IDLE.
  - Results hold until the next accepted `start`.
- `busy`=1 in DRIVE, CHECK and DONE.
- `start` in DRIVE, CHECK or DONE is ignored.
- `rst_n` low at any time, including mid-run:
  - Immediately go to IDLE.
  - All outputs and counters return to reset values.
  - No partial results are retained.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `err_flags`=0, `err_count`=0, `first_err_valid`=0, `first_err_code`=0.
- `start` high at edge N puts the FSM in DRIVE and raises `busy` from cycle N+1.
- Per-vector period is SETTLE+1 cycles.
- A run lasts 2^WIDTH × (SETTLE+1) × PASSES cycles of DRIVE/CHECK, followed by one DONE cycle. With defaults this is 24 + 1 cycles.
- `done` pulses in the cycle after the last CHECK. `busy` falls in the cycle after `done`.
- `lane_in` is sampled only in CHECK, on the rising edge that ends CHECK. It must be stable SETTLE cycles after a `stim` change.
- Result registers update on the same edge that ends CHECK.
- `err_count` saturation: when the current value plus the increment would exceed 255, the result is 255 and remains 255 for the rest of the run.

## Test plan
- **Correct wiring:** all three lanes return bit-reverse(`stim`), defaults, `start` pulse. Required: `done` 25 cycles after `busy` rises; `err_flags`=000, `err_count`=0, `first_err_valid`=0.
- **Lane 1 tied to 0:** lane 1 mismatches on 7 codes (all except 0). Required: `err_flags`=010, `err_count`=7, `first_err_code`=1.
- **Lane 2 un-reversed:** lane 2 returns `stim` unchanged. Mismatches occur on all codes except 0, 2, 5 and 7. Required: `err_flags`=100, `err_count`=4, `first_err_code`=1.
- **Lane 0 truncated to 1 bit, others correct:** lane 0 upper bits = 0, LSB = reversed bit 0. Mismatches occur on codes 1, 2, 3, 5, 6, 7. Required: `err_flags`=001, `err_count`=6, `first_err_code`=1.
- **Saturation:** PASSES=40 with lane 0 tied to 0 gives 280 raw mismatches. Required: `err_count`=255 at `done`. A second `start` in the same run is ignored; a new `start` after `done` clears the count.
- **Reset mid-run:** drop `rst_n` 10 cycles into a run. Required: in the same cycle `busy`=0, `stim`=0 and all results are 0. No `done` pulse occurs. A new run behaves as in the correct-wiring case.

Source files
------------

// File: rtl/reverse_lane_checker.sv
`timescale 1ns/1ps
// reverse_lane_checker: sweeps every WIDTH-bit code into a bit-reverse datapath and checks the returned lanes
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, honoured only in IDLE
//   stim                stimulus code driven to the datapath
//   lane_in             LANES returned lanes, lane i at [i*WIDTH +: WIDTH]
//   busy, done          run in progress / one-cycle end-of-run pulse
//   err_flags           sticky per-lane mismatch flags
//   err_count           saturating total of lane mismatches
//   first_err_valid     a mismatch has been recorded this run
//   first_err_code      stim value at the first mismatch
module reverse_lane_checker #(
    parameter int WIDTH  = 3,
    parameter int LANES  = 3,
    parameter int SETTLE = 2,
    parameter int PASSES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [WIDTH-1:0]       stim,
    input  logic [LANES*WIDTH-1:0] lane_in,
    output logic                   busy,
    output logic                   done,
    output logic [LANES-1:0]       err_flags,
    output logic [7:0]             err_count,
    output logic                   first_err_valid,
    output logic [WIDTH-1:0]       first_err_code
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int PW = $clog2(PASSES + 1);
    localparam int CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     settle_cnt;
    logic [PW-1:0]     pass_cnt;
    logic [WIDTH-1:0]  expected;
    logic [LANES-1:0]  lane_err;
    logic [CW-1:0]     n_err;
    logic [8:0]        count_sum;
    logic              wrap;

    always_comb begin
        expected = '0;
        lane_err = '0;
        n_err    = '0;
        for (int k = 0; k < WIDTH; k++)
            expected[k] = stim[WIDTH-1-k];
        for (int i = 0; i < LANES; i++) begin
            lane_err[i] = lane_in[i*WIDTH +: WIDTH] != expected;
            n_err       = n_err + CW'(lane_err[i]);
        end
        // one spare bit so the clamp at 255 sees the overflow
        count_sum = {1'b0, err_count} + 9'(n_err);
        wrap      = &stim;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        done     = state == DONE;
        unique case (state)
            IDLE:  state_nx = start ? DRIVE : IDLE;
            DRIVE: state_nx = settle_cnt == SW'(SETTLE - 1) ? CHECK : DRIVE;
            CHECK: state_nx = wrap && pass_cnt == PW'(PASSES - 1) ? DONE : DRIVE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim            <= '0;
            settle_cnt      <= '0;
            pass_cnt        <= '0;
            err_flags       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_code  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    stim       <= '0;
                    settle_cnt <= '0;
                    pass_cnt   <= '0;
                    // results survive idle time and are only wiped when a new run is accepted
                    if (start) begin
                        err_flags       <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_code  <= '0;
                    end
                end
                DRIVE: settle_cnt <= settle_cnt + 1'b1;
                CHECK: begin
                    settle_cnt <= '0;
                    stim       <= stim + 1'b1;
                    pass_cnt   <= pass_cnt + PW'(wrap);
                    err_flags  <= err_flags | lane_err;
                    err_count  <= count_sum > 9'd255 ? 8'd255 : count_sum[7:0];
                    if (!first_err_valid && |lane_err) begin
                        first_err_valid <= 1'b1;
                        first_err_code  <= stim;
                    end
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reverse_lane_checker.sv
`timescale 1ns/1ps
// tb_reverse_lane_checker: drives scripted and random lane faults and checks the checker's verdicts
module tb_reverse_lane_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sat_start = 1'b0;
    logic [2:0] stim, sat_stim;
    logic [8:0] lane_in, sat_lane_in;
    logic       busy, done, sat_busy, sat_done;
    logic [2:0] err_flags, sat_err_flags;
    logic [7:0] err_count, sat_err_count;
    logic       first_err_valid, sat_first_err_valid;
    logic [2:0] first_err_code, sat_first_err_code;
    logic [2:0] resp [3][8];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] rev3(input int c);
        return 3'(((c & 1) << 2) | (c & 2) | ((c >> 2) & 1));
    endfunction

    always_comb begin
        lane_in = '0;
        for (int l = 0; l < 3; l++)
            lane_in[l*3 +: 3] = resp[l][stim];
    end

    assign sat_lane_in = {rev3(int'(sat_stim)), rev3(int'(sat_stim)), 3'b000};

    reverse_lane_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .lane_in(lane_in),
        .busy(busy), .done(done), .err_flags(err_flags), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_code(first_err_code)
    );

    reverse_lane_checker #(.PASSES(40)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(sat_start), .stim(sat_stim), .lane_in(sat_lane_in),
        .busy(sat_busy), .done(sat_done), .err_flags(sat_err_flags), .err_count(sat_err_count),
        .first_err_valid(sat_first_err_valid), .first_err_code(sat_first_err_code)
    );

    task automatic model(input int passes, output logic [2:0] ef, output logic [7:0] ec,
                         output logic fv, output logic [2:0] fc);
        int raw = 0;
        ef = '0; fv = 1'b0; fc = '0;
        for (int p = 0; p < passes; p++)
            for (int c = 0; c < 8; c++)
                for (int l = 0; l < 3; l++)
                    if (resp[l][c] != rev3(c)) begin
                        ef[l] = 1'b1;
                        raw++;
                        if (!fv) begin fv = 1'b1; fc = 3'(c); end
                    end
        ec = 8'(raw > 255 ? 255 : raw);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stim !== 3'd0 || err_flags !== 3'd0 || err_count !== 8'd0 ||
            first_err_valid !== 1'b0 || first_err_code !== 3'd0) begin
            failures++;
            $display("FAIL reset busy=%b done=%b stim=%0d flags=%b count=%0d fv=%b fc=%0d required all 0",
                     busy, done, stim, err_flags, err_count, first_err_valid, first_err_code);
        end
        checks++;
        if (sat_busy !== 1'b0 || sat_err_count !== 8'd0 || sat_stim !== 3'd0) begin
            failures++;
            $display("FAIL reset_sat busy=%b count=%0d stim=%0d required 0", sat_busy, sat_err_count, sat_stim);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // mode 0 correct, 1 lane1 tied 0, 2 lane2 un-reversed, 3 lane0 truncated, 4 random faults
    task automatic test_wiring(input string name, input int mode, input logic use_spec,
                               input logic [2:0] s_ef, input int s_ec, input logic s_fv, input logic [2:0] s_fc);
        logic [2:0] ef, fc;
        logic [7:0] ec;
        logic       fv, got_done;
        int         busy_cycles;
        for (int c = 0; c < 8; c++)
            for (int l = 0; l < 3; l++) begin
                logic [2:0] r;
                r = rev3(c);
                if (mode == 1 && l == 1) r = 3'd0;
                if (mode == 2 && l == 2) r = 3'(c);
                if (mode == 3 && l == 0) r = {2'b00, r[0]};
                if (mode == 4 && $urandom_range(0, 3) == 0) r = 3'($urandom);
                resp[l][c] = r;
            end
        model(1, ef, ec, fv, fc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            if (busy) busy_cycles++;
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got_done || busy_cycles != 25) begin
            failures++;
            $display("FAIL %s_timing done_seen=%b busy_cycles=%0d required 1/25", name, got_done, busy_cycles);
        end
        checks++;
        if (err_flags !== ef || err_count !== ec || first_err_valid !== fv || (fv && first_err_code !== fc)) begin
            failures++;
            $display("FAIL %s_model flags=%b count=%0d fv=%b fc=%0d required %b/%0d/%b/%0d",
                     name, err_flags, err_count, first_err_valid, first_err_code, ef, ec, fv, fc);
        end
        if (use_spec) begin
            checks++;
            if (err_flags !== s_ef || err_count !== 8'(s_ec) || first_err_valid !== s_fv ||
                (s_fv && first_err_code !== s_fc)) begin
                failures++;
                $display("FAIL %s_spec flags=%b count=%0d fv=%b fc=%0d required %b/%0d/%b/%0d",
                         name, err_flags, err_count, first_err_valid, first_err_code, s_ef, s_ec, s_fv, s_fc);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== ec || err_flags !== ef) begin
            failures++;
            $display("FAIL %s_hold busy=%b done=%b count=%0d flags=%b required 0/0/%0d/%b",
                     name, busy, done, err_count, err_flags, ec, ef);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 5; n++)
            test_wiring($sformatf("random%0d", n), 4, 1'b0, 3'd0, 0, 1'b0, 3'd0);
    endtask

    task automatic test_saturation;
        logic got_done = 1'b0;
        int   busy_cycles = 0;
        int   raw = 7 * 40;
        @(negedge clk) sat_start = 1'b1;
        @(negedge clk) sat_start = 1'b0;
        for (int i = 0; i < 2000 && !got_done; i++) begin
            if (sat_busy) busy_cycles++;
            if (i == 100) sat_start = 1'b1;
            if (i == 101) sat_start = 1'b0;
            if (sat_done) got_done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got_done || busy_cycles != 8 * 3 * 40 + 1) begin
            failures++;
            $display("FAIL sat_timing done_seen=%b busy_cycles=%0d required 1/%0d", got_done, busy_cycles, 8 * 3 * 40 + 1);
        end
        checks++;
        if (sat_err_count !== 8'(raw > 255 ? 255 : raw) || sat_err_flags !== 3'b001 ||
            sat_first_err_valid !== 1'b1 || sat_first_err_code !== 3'd1) begin
            failures++;
            $display("FAIL sat_result count=%0d flags=%b fv=%b fc=%0d required 255/001/1/1",
                     sat_err_count, sat_err_flags, sat_first_err_valid, sat_first_err_code);
        end
        @(negedge clk) sat_start = 1'b1;
        @(negedge clk) sat_start = 1'b0;
        checks++;
        if (sat_busy !== 1'b1 || sat_err_count !== 8'd0 || sat_err_flags !== 3'd0 || sat_first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_restart busy=%b count=%0d flags=%b fv=%b required 1/0/000/0",
                     sat_busy, sat_err_count, sat_err_flags, sat_first_err_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        logic saw_done = 1'b0;
        for (int c = 0; c < 8; c++)
            for (int l = 0; l < 3; l++)
                resp[l][c] = l == 1 ? 3'd0 : rev3(c);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_count == 8'd0) begin
            failures++;
            $display("FAIL midrun_pre busy=%b count=%0d required busy 1 and count nonzero", busy, err_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stim !== 3'd0 || err_flags !== 3'd0 || err_count !== 8'd0 ||
            first_err_valid !== 1'b0 || first_err_code !== 3'd0) begin
            failures++;
            $display("FAIL midrun_reset busy=%b done=%b stim=%0d flags=%b count=%0d fv=%b fc=%0d required all 0",
                     busy, done, stim, err_flags, err_count, first_err_valid, first_err_code);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done activity=%b required 0", saw_done);
        end
        test_wiring("rerun", 0, 1'b1, 3'b000, 0, 1'b0, 3'd0);
    endtask

    initial begin
        test_reset;
        test_wiring("correct", 0, 1'b1, 3'b000, 0, 1'b0, 3'd0);
        test_wiring("lane1_zero", 1, 1'b1, 3'b010, 7, 1'b1, 3'd1);
        test_wiring("lane2_unrev", 2, 1'b1, 3'b100, 4, 1'b1, 3'd1);
        test_wiring("lane0_trunc", 3, 1'b1, 3'b001, 6, 1'b1, 3'd1);
        test_random;
        test_saturation;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
